snake_step_ctrl: RTL and testbench
==================================

Name: snake_step_ctrl

Overview:
Game-sequencing controller for the snake engine. Conditions the four direction buttons (synchronise, debounce, edge-detect). Enforces the no-reverse rule. Paces snake moves off the VGA frame tick and issues one move per step to the engine via a req/ack handshake. Owns the game state machine (idle / running / over) and sits between the top-level input pins and the snake datapath.

Parameters:
DEB_CYCLES, 16, consecutive clk cycles a synchronised button must be stable before its debounced level changes
FRAMES_PER_STEP, 8, frame_start pulses per snake move (legal 2..255)
CNT_W, 8, width of frame and debounce counters

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous assert, active-low
btn_up  in  1  raw button, active-high, asynchronous to clk
btn_down  in  1  raw button
btn_left  in  1  raw button
btn_right  in  1  raw button
frame_start  in  1  one-cycle pulse per video frame from VGA timing
step_ack  in  1  engine completed requested move (one-cycle pulse)
collision  in  1  engine collision result; valid only in the cycle step_ack=1
step_req  out  1  move request; held high until step_ack
dir  out  2  committed direction for the current move: 00 up, 01 down, 10 left, 11 right
state  out  2  00 IDLE, 01 RUN, 10 WAIT_ACK, 11 OVER
game_over  out  1  high while state=OVER

Behaviour:
- Reset (async, rst_n=0): step_req=0, dir=11, pending_dir=11, state=IDLE, game_over=0. All counters and synchroniser/debounce flops are 0.
- Input path: per button, 2-flop synchroniser, then debounce counter. Counter resets on any mismatch with the debounced level. Debounced level flips when count reaches DEB_CYCLES-1. Press event = one-cycle pulse on debounced 0->1. Latency from a stable raw edge to the press pulse = 2 + DEB_CYCLES cycles.
- Simultaneous press events in the same cycle: priority up > down > left > right; only the winner is used.
- pending_dir: a press updates it unless the press direction is the opposite of dir (opposite = same bit1, differing bit0). An opposite press is ignored. The last accepted press before a step wins.
- FSM:
  - IDLE: frame counter held at 0. Any press event -> RUN; dir and pending_dir load the pressed direction.
  - RUN: counts frame_start pulses. When count = FRAMES_PER_STEP-1 and frame_start=1: count resets to 0, dir <= pending_dir, step_req <= 1, and state goes to WAIT_ACK.
  - WAIT_ACK: step_req stays 1. frame_start pulses are ignored, not counted. On step_ack, step_req <= 0. If collision=1 -> OVER, otherwise -> RUN. step_ack outside WAIT_ACK is ignored.
  - OVER: game_over=1. Press events are ignored until all four debounced levels have been 0 at least once. The next press after that -> IDLE, with dir=11 and pending_dir=11.
- dir changes only at step issue or at IDLE/OVER exit, never while step_req=1.
- Press events in WAIT_ACK update pending_dir normally, checked against the current dir.
- Reset mid-handshake: step_req drops immediately (asynchronous). The engine must tolerate an abandoned request.

Optional Feature:
SNAKE_SPEEDUP_EN
- Defined:
  - An internal period register initialises to FRAMES_PER_STEP on entry to RUN from IDLE.
  - It replaces FRAMES_PER_STEP in the step compare.
  - Every 16th acked non-collision step decrements it by 1, saturating at 2.
- Not defined: the period is the constant FRAMES_PER_STEP and no step counter is built.

Test Plan:
- Reset, no presses, 100 frame_start pulses -> state=00, step_req=0, dir=11.
- DEB_CYCLES=4. btn_left high for 3 cycles then low -> no press, state stays IDLE. btn_left high for 10 cycles -> state=01 and dir=10, exactly 6 cycles after the rising edge.
- RUN with dir=11, FRAMES_PER_STEP=8 -> step_req rises in the cycle after the 8th frame_start. Ack without collision -> step_req=0, state=01, the next request follows 8 more frames.
- RUN with dir=11. Press left, then up, before the step -> issued dir=00. Separately, press left only while dir=11 -> ignored, issued dir stays 11.
- Press up and right in the same cycle -> pending_dir=00.
- step_ack with collision=1 -> state=11, game_over=1. Button already held -> no exit. Release, then press -> state=00, dir=11.
- With SNAKE_SPEEDUP_EN and FRAMES_PER_STEP=4: 16 acked steps -> gap of 3 frames. 32 steps -> 2. 48 steps -> stays at 2.

Source files
------------

// File: rtl/snake_step_ctrl.sv
// Snake game sequencer: button conditioning, no-reverse filtering, frame-paced
// move requests to the engine and the idle/run/wait/over FSM. Optional: SNAKE_SPEEDUP_EN.
module snake_step_ctrl #(
  parameter int DEB_CYCLES      = 16,
  parameter int FRAMES_PER_STEP = 8,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       frame_start,
  input  logic       step_ack,
  input  logic       collision,
  output logic       step_req,
  output logic [1:0] dir,
  output logic [1:0] state,
  output logic       game_over
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_WAIT = 2'b10,
    ST_OVER = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] FPS_INIT = CNT_W'(FRAMES_PER_STEP);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r, state_next_s;
  logic [3:0]       btn_raw_s, sync1_r, sync2_r, deb_r, press_s;
  logic [3:0]       rel_r, rel_next_s;
  logic [CNT_W-1:0] deb_cnt_r [4];
  logic [CNT_W-1:0] fcnt_r, fcnt_next_s, period_s;
  logic [1:0]       dir_next_s, pend_r, pend_next_s, press_dir_s;
  logic             any_press_s, accept_s, step_due_s;

  // Bit index matches the direction code: 0 up, 1 down, 2 left, 3 right
  assign btn_raw_s = {btn_right, btn_left, btn_down, btn_up};

`ifdef SNAKE_SPEEDUP_EN
  localparam logic [CNT_W-1:0] PERIOD_MIN = CNT_W'(2);
  logic [CNT_W-1:0] period_r, period_next_s;
  logic [3:0]       spd_cnt_r, spd_cnt_next_s;
  assign period_s = period_r;
`else
  assign period_s = FPS_INIT;
`endif

  // Synchronise raw buttons and flip each debounced level after a stable run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
      deb_r   <= 4'b0000;
      for (int i = 0; i < 4; i++) deb_cnt_r[i] <= CNT_ZERO;
    end else begin
      sync1_r <= btn_raw_s;
      sync2_r <= sync1_r;
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          deb_cnt_r[i] <= CNT_ZERO;
        end else if (deb_cnt_r[i] == DEB_LAST) begin
          deb_cnt_r[i] <= CNT_ZERO;
          deb_r[i]     <= sync2_r[i];
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  // Press fires in the cycle the debounced level is about to rise, so the FSM
  // acts on the same edge that flips the level
  always_comb begin
    press_s = 4'b0000;
    for (int i = 0; i < 4; i++)
      press_s[i] = sync2_r[i] & ~deb_r[i] & (deb_cnt_r[i] == DEB_LAST);
  end

  // Fixed priority among simultaneous presses: up > down > left > right
  always_comb begin
    press_dir_s = 2'b11;
    if (press_s[0])      press_dir_s = 2'b00;
    else if (press_s[1]) press_dir_s = 2'b01;
    else if (press_s[2]) press_dir_s = 2'b10;
    else                 press_dir_s = 2'b11;
  end

  assign any_press_s = |press_s;
  assign accept_s    = any_press_s && (press_dir_s != {dir[1], ~dir[0]});
  assign step_due_s  = frame_start && (fcnt_r == (period_s - CNT_ONE));

  // Game FSM next-state and datapath next values
  always_comb begin
    state_next_s = state_r;
    dir_next_s   = dir;
    pend_next_s  = pend_r;
    fcnt_next_s  = fcnt_r;
    rel_next_s   = rel_r;
`ifdef SNAKE_SPEEDUP_EN
    period_next_s  = period_r;
    spd_cnt_next_s = spd_cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        fcnt_next_s = CNT_ZERO;
        if (any_press_s) begin
          state_next_s = ST_RUN;
          dir_next_s   = press_dir_s;
          pend_next_s  = press_dir_s;
`ifdef SNAKE_SPEEDUP_EN
          period_next_s  = FPS_INIT;
          spd_cnt_next_s = 4'd0;
`endif
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s) pend_next_s = press_dir_s;
        else          pend_next_s = pend_r;
        if (step_due_s) begin
          fcnt_next_s  = CNT_ZERO;
          dir_next_s   = pend_r;
          state_next_s = ST_WAIT;
        end else if (frame_start) begin
          fcnt_next_s = fcnt_r + CNT_ONE;
        end else begin
          fcnt_next_s = fcnt_r;
        end
      end
      ST_WAIT: begin
        if (accept_s) pend_next_s = press_dir_s;
        else          pend_next_s = pend_r;
        if (step_ack) begin
          if (collision) begin
            state_next_s = ST_OVER;
            rel_next_s   = 4'b0000;
          end else begin
            state_next_s = ST_RUN;
`ifdef SNAKE_SPEEDUP_EN
            spd_cnt_next_s = spd_cnt_r + 4'd1;
            if ((spd_cnt_r == 4'd15) && (period_r > PERIOD_MIN)) period_next_s = period_r - CNT_ONE;
            else                                                 period_next_s = period_r;
`endif
          end
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_OVER: begin
        fcnt_next_s = CNT_ZERO;
        rel_next_s  = rel_r | ~deb_r;
        // Exit only once every button has been seen released since the crash
        if (any_press_s && (rel_r == 4'hF)) begin
          state_next_s = ST_IDLE;
          dir_next_s   = 2'b11;
          pend_next_s  = 2'b11;
        end else begin
          state_next_s = ST_OVER;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      dir       <= 2'b11;
      pend_r    <= 2'b11;
      fcnt_r    <= CNT_ZERO;
      rel_r     <= 4'b0000;
      step_req  <= 1'b0;
      game_over <= 1'b0;
`ifdef SNAKE_SPEEDUP_EN
      period_r  <= FPS_INIT;
      spd_cnt_r <= 4'd0;
`endif
    end else begin
      state_r   <= state_next_s;
      dir       <= dir_next_s;
      pend_r    <= pend_next_s;
      fcnt_r    <= fcnt_next_s;
      rel_r     <= rel_next_s;
      step_req  <= (state_next_s == ST_WAIT);
      game_over <= (state_next_s == ST_OVER);
`ifdef SNAKE_SPEEDUP_EN
      period_r  <= period_next_s;
      spd_cnt_r <= spd_cnt_next_s;
`endif
    end
  end

  assign state = state_r;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Bench for snake_step_ctrl: directed game scenarios and random stimulus,
// all checked every cycle against a behavioural game model.
module tb_snake_step_ctrl;

  localparam int DEB = 4;
`ifdef SNAKE_SPEEDUP_EN
  localparam int FPS = 4;
  localparam bit SPD = 1'b1;
`else
  localparam int FPS = 8;
  localparam bit SPD = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       frame_start = 1'b0, step_ack = 1'b0, collision = 1'b0;
  logic       step_req, game_over;
  logic [1:0] dir, state;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  snake_step_ctrl #(.DEB_CYCLES(DEB), .FRAMES_PER_STEP(FPS), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .frame_start(frame_start), .step_ack(step_ack), .collision(collision),
    .step_req(step_req), .dir(dir), .state(state), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Game phase: 0 idle, 1 running, 2 waiting for engine, 3 game over
  int         m_state, m_frames, m_period, m_okacks;
  logic [1:0] m_dir, m_pend;
  logic [3:0] m_deb, m_rel;
  logic [3:0] raw_q[$];   // raw button samples, oldest first

  task automatic model_reset();
    m_state = 0; m_dir = 2'b11; m_pend = 2'b11;
    m_frames = 0; m_period = FPS; m_okacks = 0;
    m_deb = 4'b0000; m_rel = 4'b0000;
    raw_q.delete();
    repeat (DEB + 2) raw_q.push_back(4'b0000);
  endtask

  task automatic model_step();
    logic [3:0] flip, press, old_deb;
    logic [1:0] pd, old_pend;
    bit any, accept;
    // A level flips once the DEB samples that reached the debouncer (2 cycles late) all disagree with it
    for (int i = 0; i < 4; i++) begin
      flip[i] = 1'b1;
      for (int k = 1; k <= DEB; k++) if (raw_q[k][i] == m_deb[i]) flip[i] = 1'b0;
    end
    press   = flip & ~m_deb;
    old_deb = m_deb;
    m_deb   = m_deb ^ flip;
    raw_q.push_back({btn_right, btn_left, btn_down, btn_up});
    void'(raw_q.pop_front());
    any = (press != 4'b0000);
    pd  = 2'b11;
    for (int i = 3; i >= 0; i--) if (press[i]) pd = 2'(i);
    accept   = any && (pd != (m_dir ^ 2'b01));
    old_pend = m_pend;
    case (m_state)
      0: if (any) begin
           m_state = 1; m_dir = pd; m_pend = pd;
           m_frames = 0; m_period = FPS; m_okacks = 0;
         end
      1: begin
           if (accept) m_pend = pd;
           if (frame_start) begin
             m_frames++;
             if (m_frames == m_period) begin
               m_frames = 0; m_dir = old_pend; m_state = 2;
             end
           end
         end
      2: begin
           if (accept) m_pend = pd;
           if (step_ack) begin
             if (collision) begin
               m_state = 3; m_rel = 4'b0000;
             end else begin
               m_state = 1;
               m_okacks++;
               if (SPD && (m_okacks % 16 == 0) && (m_period > 2)) m_period--;
             end
           end
         end
      default: begin
           if (any && (m_rel == 4'hF)) begin
             m_state = 0; m_dir = 2'b11; m_pend = 2'b11;
           end
           m_rel = m_rel | ~old_deb;
         end
    endcase
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                     input logic [31:0] exp);
    check({nm, " dut"}, dut_v, exp);
    check({nm, " model"}, mdl_v, exp);
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("state",     32'(state),     32'(m_state));
      check("dir",       32'(dir),       32'(m_dir));
      check("step_req",  32'(step_req),  32'(m_state == 2));
      check("game_over", 32'(game_over), 32'(m_state == 3));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_start = 1'b1; tick(1);
      frame_start = 1'b0; tick(1);
    end
  endtask

  task automatic set_btns(input logic [3:0] m);
    {btn_right, btn_left, btn_down, btn_up} = m;
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    set_btns(m);
    tick(hold);
    set_btns(4'b0000);
    tick(DEB + 4);
  endtask

  task automatic ack(input logic c);
    step_ack = 1'b1; collision = c;
    tick(1);
    step_ack = 1'b0; collision = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n;
    bit done;
    tick(3);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Idle with frames only: nothing moves
    frames(100);
    lit("idle state", 32'(state), 32'(m_state), 32'd0);
    lit("idle req",   32'(step_req), 32'(m_state == 2), 32'd0);
    lit("idle dir",   32'(dir), 32'(m_dir), 32'd3);

    // Glitch shorter than debounce window is ignored
    btn_left = 1'b1; tick(3); btn_left = 1'b0; tick(10);
    lit("glitch state", 32'(state), 32'(m_state), 32'd0);

    // Latency from raw edge to RUN
    btn_left = 1'b1; lat = 0; done = 1'b0;
    for (int c = 1; c <= 20 && !done; c++) begin
      @(posedge clk); #1;
      if (state == 2'b01) begin lat = c; done = 1'b1; end
    end
    check("press latency", 32'(lat), 32'd6);
    @(negedge clk);
    lit("start dir", 32'(dir), 32'(m_dir), 32'd2);
    tick(3); btn_left = 1'b0; tick(DEB + 4);

    // Fresh game moving right
    do_reset();
    press(4'b1000, 8);
    lit("run state", 32'(state), 32'(m_state), 32'd1);
    frames(FPS - 1);
    lit("req before step", 32'(step_req), 32'(m_state == 2), 32'd0);
    frames(1);
    lit("req at step", 32'(step_req), 32'(m_state == 2), 32'd1);
    frames(3);
    lit("req held", 32'(step_req), 32'(m_state == 2), 32'd1);
    ack(1'b0);
    lit("req after ack", 32'(step_req), 32'(m_state == 2), 32'd0);
    lit("state after ack", 32'(state), 32'(m_state), 32'd1);
    frames(FPS - 1);
    lit("req second early", 32'(step_req), 32'(m_state == 2), 32'd0);
    frames(1);
    lit("req second", 32'(step_req), 32'(m_state == 2), 32'd1);
    ack(1'b0);

    // Reverse press ignored, later legal press wins
    press(4'b0100, 8);
    press(4'b0001, 8);
    frames(FPS);
    lit("issued up", 32'(dir), 32'(m_dir), 32'd0);
    ack(1'b0);
    press(4'b1000, 8);
    frames(FPS);
    ack(1'b0);
    press(4'b0100, 8);
    frames(FPS);
    lit("reverse ignored", 32'(dir), 32'(m_dir), 32'd3);
    ack(1'b0);

    // Simultaneous up+right: up wins
    press(4'b1001, 8);
    frames(FPS);
    lit("priority up", 32'(dir), 32'(m_dir), 32'd0);
    ack(1'b0);

    // Crash with a button held; exit only after full release
    btn_down = 1'b1;
    frames(FPS);
    ack(1'b1);
    lit("over state", 32'(state), 32'(m_state), 32'd3);
    lit("over flag", 32'(game_over), 32'(m_state == 3), 32'd1);
    btn_up = 1'b1; tick(10);
    lit("held no exit", 32'(state), 32'(m_state), 32'd3);
    btn_up = 1'b0; btn_down = 1'b0; tick(DEB + 6);
    press(4'b0100, 8);
    lit("exit state", 32'(state), 32'(m_state), 32'd0);
    lit("exit dir", 32'(dir), 32'(m_dir), 32'd3);
    lit("exit flag", 32'(game_over), 32'(m_state == 3), 32'd0);

    // Reset in the middle of a handshake drops the request at once
    press(4'b1000, 8);
    frames(FPS);
    #2 rst_n = 1'b0;
    #1;
    lit("async req", 32'(step_req), 32'(m_state == 2), 32'd0);
    lit("async state", 32'(state), 32'(m_state), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

`ifdef SNAKE_SPEEDUP_EN
    // Speedup: period shortens every 16 clean steps, floor of 2 frames
    press(4'b1000, 8);
    for (int s = 1; s <= 49; s++) begin
      n = 0;
      while (step_req !== 1'b1 && n < 20) begin frames(1); n++; end
      if (s == 1)  check("gap step 1",  32'(n), 32'd4);
      if (s == 17) check("gap step 17", 32'(n), 32'd3);
      if (s == 33) check("gap step 33", 32'(n), 32'd2);
      if (s == 49) check("gap step 49", 32'(n), 32'd2);
      ack(1'b0);
    end
    do_reset();
`endif

    // Random play against the model
    for (int c = 0; c < 4000; c++) begin
      logic [3:0] b;
      b = {btn_right, btn_left, btn_down, btn_up};
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 11) == 0) b[i] = ~b[i];
      set_btns(b);
      frame_start = ($urandom_range(0, 2) == 0);
      step_ack    = ($urandom_range(0, 3) == 0);
      collision   = ($urandom_range(0, 5) == 0);
      tick(1);
    end
    set_btns(4'b0000);
    frame_start = 1'b0; step_ack = 1'b0; collision = 1'b0;
    tick(DEB + 4);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
